// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage with a two-state wait FSM and a write-back register bank.
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   pc_Ma, alu_out_Ma, rs2_Ma       PC, ALU result / effective address, store data
//   inst_Ma                         instruction (0 = bubble)
//   dmem_req, dmem_we, dmem_addr,   data-memory request, store flag, word address,
//   dmem_wdata, dmem_be             lane-replicated store data, byte enables
//   dmem_ready, dmem_rdata          completion strobe and read data
//   stall_Ma                        holds the upstream stages
//   mem_err                         registered one-cycle error pulse (timeout or trap)
//   pc_Wb, alu_out_Wb,              write-back pipeline registers
//   mem_data_Wb, inst_Wb
// Optional feature: define MA_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module ma_stage #(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_Ma,
   input  logic [31:0] alu_out_Ma,
   input  logic [31:0] rs2_Ma,
   input  logic [31:0] inst_Ma,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        stall_Ma,
   output logic        mem_err,
   output logic [31:0] pc_Wb,
   output logic [31:0] alu_out_Wb,
   output logic [31:0] mem_data_Wb,
   output logic [31:0] inst_Wb
);
   localparam logic [7:0] WMAX = 8'(WAIT_MAX);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t      state, state_nx;
   logic [7:0]  cnt;
   logic [2:0]  f3;
   logic [1:0]  a;
   logic        is_load, is_store, is_st_req, trap, timeout, req, take;
   logic [7:0]  lb;
   logic [15:0] lh;
   logic [31:0] ld_data;
   assign f3       = inst_Ma[14:12];
   assign a        = alu_out_Ma[1:0];
   assign is_load  = inst_Ma[6:0] == 7'b0000011;
   assign is_store = inst_Ma[6:0] == 7'b0100011;
`ifdef MA_MISALIGN_TRAP_EN
   // Halfword accesses need an even address, word accesses a word-aligned one.
   assign trap = (is_load || is_store) && state == IDLE &&
                 (((f3 == 3'b001 || (is_load && f3 == 3'b101)) && a[0]) ||
                  (f3 == 3'b010 && a != 2'b00));
`else
   assign trap = 1'b0;
`endif
   assign lb = dmem_rdata[{a, 3'b000} +: 8];
   assign lh = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
   assign ld_data = f3 == 3'b000 ? {{24{lb[7]}}, lb} :
                    f3 == 3'b100 ? {24'b0, lb} :
                    f3 == 3'b001 ? {{16{lh[15]}}, lh} :
                    f3 == 3'b101 ? {16'b0, lh} :
                    f3 == 3'b010 ? dmem_rdata : 32'b0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req && !dmem_ready) state_nx = BUSY;
         BUSY:    if (dmem_ready || timeout) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // Request fields come straight from the stage inputs; while stalled the upstream
   // register holds them, so they stay stable for the whole BUSY period.
   always_comb begin
      timeout    = state == BUSY && cnt == WMAX && !dmem_ready;
      req        = rst_n && (is_load || is_store) && !trap;
      is_st_req  = req && is_store;
      stall_Ma   = req && !dmem_ready && !timeout;
      take       = !stall_Ma && !timeout && !trap;
      dmem_req   = req;
      dmem_we    = is_st_req;
      dmem_addr  = req ? {alu_out_Ma[31:2], 2'b00} : 32'b0;
      dmem_be    = !is_st_req    ? 4'b0000 :
                   f3 == 3'b000 ? 4'b0001 << a :
                   f3 == 3'b001 ? 4'b0011 << {a[1], 1'b0} :
                   f3 == 3'b010 ? 4'b1111 : 4'b0000;
      dmem_wdata = !is_st_req    ? 32'b0 :
                   f3 == 3'b000 ? {4{rs2_Ma[7:0]}} :
                   f3 == 3'b001 ? {2{rs2_Ma[15:0]}} : rs2_Ma;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= 8'd0;
         mem_err     <= 1'b0;
         pc_Wb       <= 32'b0;
         alu_out_Wb  <= 32'b0;
         mem_data_Wb <= 32'b0;
         inst_Wb     <= 32'b0;
      end else begin
         cnt         <= state == BUSY ? cnt + 8'd1 : 8'd0;
         mem_err     <= timeout || trap;
         pc_Wb       <= take ? pc_Ma : 32'b0;
         alu_out_Wb  <= take ? alu_out_Ma : 32'b0;
         mem_data_Wb <= take && is_load ? ld_data : 32'b0;
         inst_Wb     <= take ? inst_Ma : 32'b0;
      end
   end
endmodule

// File: tb/tb_ma_stage.sv
// tb_ma_stage: self-checking bench for ma_stage (directed scenarios plus randomized traffic).
module tb_ma_stage;
   localparam int WM = 15;
   localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_ALU = 7'b0110011;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [31:0] pc_Ma, alu_out_Ma, rs2_Ma, inst_Ma, dmem_rdata;
   logic dmem_ready, dmem_req, dmem_we, stall_Ma, mem_err;
   logic [31:0] dmem_addr, dmem_wdata, pc_Wb, alu_out_Wb, mem_data_Wb, inst_Wb;
   logic [3:0] dmem_be;
   int errs = 0, checks = 0;
   always #5 clk = ~clk;
   ma_stage #(.WAIT_MAX(WM)) dut (
      .clk(clk), .rst_n(rst_n), .pc_Ma(pc_Ma), .alu_out_Ma(alu_out_Ma), .rs2_Ma(rs2_Ma),
      .inst_Ma(inst_Ma), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .stall_Ma(stall_Ma), .mem_err(mem_err), .pc_Wb(pc_Wb),
      .alu_out_Wb(alu_out_Wb), .mem_data_Wb(mem_data_Wb), .inst_Wb(inst_Wb));
   function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
      return {7'h01, 5'd5, 5'd6, f3, 5'd7, op};
   endfunction
   function automatic logic [31:0] exp_load(input logic [31:0] d, input int a, input int f3);
      logic [31:0] b, h;
      b = (d >> (8 * a)) & 32'hFF;
      h = (d >> (16 * (a / 2))) & 32'hFFFF;
      case (f3)
         0: return b >= 128 ? b + 32'hFFFFFF00 : b;
         4: return b;
         1: return h >= 32768 ? h + 32'hFFFF0000 : h;
         5: return h;
         2: return d;
         default: return 32'h0;
      endcase
   endfunction
   function automatic logic [3:0] exp_be(input int a, input int f3);
      return f3 == 0 ? 4'(1 << a) : f3 == 1 ? 4'(3 << (2 * (a / 2))) : f3 == 2 ? 4'hF : 4'h0;
   endfunction
   function automatic logic [31:0] exp_wd(input logic [31:0] d, input int f3);
      return f3 == 0 ? (d & 32'hFF) * 32'h01010101 : f3 == 1 ? (d & 32'hFFFF) * 32'h00010001 : d;
   endfunction
   function automatic bit exp_mis(input bit mem, input bit ld, input int f3, input int a);
`ifdef MA_MISALIGN_TRAP_EN
      return mem && (((f3 == 1 || (ld && f3 == 5)) && a % 2 == 1) || (f3 == 2 && a != 0));
`else
      return 1'b0;
`endif
   endfunction
   task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] rs2, input logic rdy, input logic [31:0] rd);
      inst_Ma = inst; pc_Ma = pc; alu_out_Ma = alu; rs2_Ma = rs2; dmem_ready = rdy; dmem_rdata = rd;
   endtask
   task automatic test_reset;
      drive(mk(OP_LD, 3'd2), 32'h40, 32'h100, 32'h0, 1'b0, 32'h1);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (dmem_req !== 1'b0) begin errs++; $display("FAIL reset_req got %b want 0", dmem_req); end
      checks++; if (stall_Ma !== 1'b0) begin errs++; $display("FAIL reset_stall got %b want 0", stall_Ma); end
      checks++; if (mem_err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", mem_err); end
      checks++; if ({pc_Wb, alu_out_Wb, mem_data_Wb, inst_Wb} !== 128'h0) begin errs++; $display("FAIL reset_wb got %h %h %h %h want 0", pc_Wb, alu_out_Wb, mem_data_Wb, inst_Wb); end
      drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (inst_Wb !== 32'h0 || mem_err !== 1'b0) begin errs++; $display("FAIL reset_release got inst=%h err=%b want 0 0", inst_Wb, mem_err); end
   endtask
   task automatic test_lw;
      @(negedge clk); drive(mk(OP_LD, 3'd2), 32'h1000, 32'h100, 32'h55, 1'b1, 32'hDEADBEEF); #1;
      checks++; if (dmem_req !== 1'b1 || stall_Ma !== 1'b0) begin errs++; $display("FAIL lw_req got req=%b stall=%b want 1 0", dmem_req, stall_Ma); end
      checks++; if (dmem_addr !== 32'h100 || dmem_we !== 1'b0 || dmem_be !== 4'h0) begin errs++; $display("FAIL lw_bus got addr=%h we=%b be=%h want 100 0 0", dmem_addr, dmem_we, dmem_be); end
      @(posedge clk); #1;
      checks++; if (mem_data_Wb !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_data got %h want deadbeef", mem_data_Wb); end
      checks++; if (inst_Wb !== mk(OP_LD, 3'd2) || pc_Wb !== 32'h1000) begin errs++; $display("FAIL lw_wb got inst=%h pc=%h want %h 1000", inst_Wb, pc_Wb, mk(OP_LD, 3'd2)); end
   endtask
   task automatic test_lb_wait;
      int ns;
      ns = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); drive(mk(OP_LD, 3'd0), 32'h2000, 32'h103, 32'h0, c == 3, c == 3 ? 32'h80FFFFFF : 32'h0); #1;
         if (stall_Ma) ns++;
         checks++; if (dmem_req !== 1'b1) begin errs++; $display("FAIL lb_req cycle %0d got %b want 1", c, dmem_req); end
         @(posedge clk); #1;
         if (c < 3) begin
            checks++; if (inst_Wb !== 32'h0 || pc_Wb !== 32'h0) begin errs++; $display("FAIL lb_bubble cycle %0d got inst=%h pc=%h want 0 0", c, inst_Wb, pc_Wb); end
         end
      end
      checks++; if (ns != 3) begin errs++; $display("FAIL lb_stall_cycles got %0d want 3", ns); end
      checks++; if (mem_data_Wb !== 32'hFFFFFF80) begin errs++; $display("FAIL lb_data got %h want ffffff80", mem_data_Wb); end
   endtask
   task automatic test_sh;
      @(negedge clk); drive(mk(OP_ST, 3'd1), 32'h2400, 32'h102, 32'h1234ABCD, 1'b1, 32'h0); #1;
      checks++; if (dmem_we !== 1'b1 || dmem_be !== 4'b1100) begin errs++; $display("FAIL sh_be got we=%b be=%b want 1 1100", dmem_we, dmem_be); end
      checks++; if (dmem_wdata !== 32'hABCDABCD || dmem_addr !== 32'h100) begin errs++; $display("FAIL sh_wdata got %h addr=%h want abcdabcd 100", dmem_wdata, dmem_addr); end
      @(posedge clk); #1;
      checks++; if (inst_Wb !== mk(OP_ST, 3'd1) || mem_data_Wb !== 32'h0) begin errs++; $display("FAIL sh_wb got inst=%h data=%h want %h 0", inst_Wb, mem_data_Wb, mk(OP_ST, 3'd1)); end
   endtask
   task automatic test_timeout;
      int n;
      n = 0;
      @(negedge clk); drive(mk(OP_LD, 3'd2), 32'h2800, 32'h200, 32'h0, 1'b0, 32'h0); #1;
      for (int c = 0; c < 40; c++) begin
         if (!stall_Ma) break;
         n++;
         @(posedge clk); #1;
         checks++; if (mem_err !== 1'b0 || inst_Wb !== 32'h0) begin errs++; $display("FAIL to_wait cycle %0d got err=%b inst=%h want 0 0", c, mem_err, inst_Wb); end
         @(negedge clk); #1;
      end
      // the issuing cycle plus WAIT_MAX stalled BUSY cycles
      checks++; if (n != WM + 1) begin errs++; $display("FAIL to_stall_cycles got %0d want %0d", n, WM + 1); end
      checks++; if (dmem_req !== 1'b1) begin errs++; $display("FAIL to_req got %b want 1", dmem_req); end
      @(posedge clk); #1;
      checks++; if (mem_err !== 1'b1 || inst_Wb !== 32'h0 || mem_data_Wb !== 32'h0) begin errs++; $display("FAIL to_err got err=%b inst=%h data=%h want 1 0 0", mem_err, inst_Wb, mem_data_Wb); end
      @(negedge clk); drive(mk(OP_LD, 3'd2), 32'h2900, 32'h204, 32'h0, 1'b1, 32'h600DF00D); #1;
      checks++; if (stall_Ma !== 1'b0 || dmem_req !== 1'b1) begin errs++; $display("FAIL to_idle got stall=%b req=%b want 0 1", stall_Ma, dmem_req); end
      @(posedge clk); #1;
      checks++; if (mem_err !== 1'b0 || mem_data_Wb !== 32'h600DF00D) begin errs++; $display("FAIL to_after got err=%b data=%h want 0 600df00d", mem_err, mem_data_Wb); end
   endtask
   task automatic test_ready_at_limit;
      for (int c = 0; c <= WM + 1; c++) begin
         @(negedge clk); drive(mk(OP_LD, 3'd2), 32'h3100, 32'h310, 32'h0, c == WM + 1, 32'hA5A50F0F); #1;
         checks++; if (stall_Ma !== (c < WM + 1)) begin errs++; $display("FAIL lim_stall cycle %0d got %b want %b", c, stall_Ma, c < WM + 1); end
         @(posedge clk); #1;
         checks++; if (mem_err !== 1'b0) begin errs++; $display("FAIL lim_err cycle %0d got %b want 0", c, mem_err); end
      end
      checks++; if (mem_data_Wb !== 32'hA5A50F0F) begin errs++; $display("FAIL lim_data got %h want a5a50f0f", mem_data_Wb); end
   endtask
   task automatic test_misalign;
      @(negedge clk); drive(mk(OP_LD, 3'd2), 32'h3200, 32'h101, 32'h0, 1'b1, 32'hCAFEF00D); #1;
`ifdef MA_MISALIGN_TRAP_EN
      checks++; if (dmem_req !== 1'b0 || stall_Ma !== 1'b0) begin errs++; $display("FAIL mis_req got req=%b stall=%b want 0 0", dmem_req, stall_Ma); end
      @(posedge clk); #1;
      checks++; if (mem_err !== 1'b1 || inst_Wb !== 32'h0) begin errs++; $display("FAIL mis_err got err=%b inst=%h want 1 0", mem_err, inst_Wb); end
      @(negedge clk); drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(posedge clk); #1;
      checks++; if (mem_err !== 1'b0) begin errs++; $display("FAIL mis_pulse got %b want 0", mem_err); end
`else
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin errs++; $display("FAIL mis_req got req=%b addr=%h want 1 100", dmem_req, dmem_addr); end
      @(posedge clk); #1;
      checks++; if (mem_err !== 1'b0 || mem_data_Wb !== 32'hCAFEF00D) begin errs++; $display("FAIL mis_data got err=%b data=%h want 0 cafef00d", mem_err, mem_data_Wb); end
`endif
   endtask
   task automatic test_reset_busy;
      @(negedge clk); drive(mk(OP_LD, 3'd2), 32'h3000, 32'h300, 32'h0, 1'b0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (stall_Ma !== 1'b1) begin errs++; $display("FAIL rb_busy got %b want 1", stall_Ma); end
      rst_n = 1'b0; #1;
      checks++; if (dmem_req !== 1'b0 || stall_Ma !== 1'b0 || mem_err !== 1'b0) begin errs++; $display("FAIL rb_ctl got req=%b stall=%b err=%b want 0 0 0", dmem_req, stall_Ma, mem_err); end
      checks++; if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== 69'h0) begin errs++; $display("FAIL rb_bus got we=%b be=%h addr=%h wd=%h want 0", dmem_we, dmem_be, dmem_addr, dmem_wdata); end
      checks++; if ({pc_Wb, alu_out_Wb, mem_data_Wb, inst_Wb} !== 128'h0) begin errs++; $display("FAIL rb_wb got %h %h %h %h want 0", pc_Wb, alu_out_Wb, mem_data_Wb, inst_Wb); end
      @(posedge clk); #1;
      @(negedge clk); rst_n = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'h13579BDF; #1;
      checks++; if (dmem_req !== 1'b1 || stall_Ma !== 1'b0) begin errs++; $display("FAIL rb_resume got req=%b stall=%b want 1 0", dmem_req, stall_Ma); end
      @(posedge clk); #1;
      checks++; if (mem_err !== 1'b0 || mem_data_Wb !== 32'h13579BDF) begin errs++; $display("FAIL rb_data got err=%b data=%h want 0 13579bdf", mem_err, mem_data_Wb); end
   endtask
   task automatic test_random(input int n);
      int typ, f3, a, d;
      bit ld, st, mem, mis, req_e;
      logic [31:0] inst, pc, alu, rs2, rd, wb_inst, wb_pc, wb_alu, wb_data;
      for (int k = 0; k < n; k++) begin
         typ = $urandom_range(0, 3);
         ld = typ == 0; st = typ == 1; mem = ld || st;
         f3 = ld ? $urandom_range(0, 7) : st ? $urandom_range(0, 2) : $urandom_range(0, 7);
         inst = ld ? mk(OP_LD, 3'(f3)) : st ? mk(OP_ST, 3'(f3)) : typ == 2 ? mk(OP_ALU, 3'(f3)) : 32'h0;
         pc = $urandom; alu = $urandom; rs2 = $urandom;
         a = int'(alu % 4);
         mis = exp_mis(mem, ld, f3, a);
         req_e = mem && !mis;
         d = req_e ? $urandom_range(0, 3) : 0;
         for (int c = 0; c <= d; c++) begin
            rd = $urandom;
            @(negedge clk); drive(inst, pc, alu, rs2, c == d, rd); #1;
            checks++; if (dmem_req !== req_e) begin errs++; $display("FAIL rnd_req #%0d got %b want %b", k, dmem_req, req_e); end
            checks++; if (stall_Ma !== (req_e && c < d)) begin errs++; $display("FAIL rnd_stall #%0d got %b want %b", k, stall_Ma, req_e && c < d); end
            if (req_e) begin
               checks++; if (dmem_addr !== (alu & 32'hFFFFFFFC) || dmem_we !== st) begin errs++; $display("FAIL rnd_addr #%0d got %h we=%b want %h %b", k, dmem_addr, dmem_we, alu & 32'hFFFFFFFC, st); end
               checks++; if (dmem_be !== (st ? exp_be(a, f3) : 4'h0)) begin errs++; $display("FAIL rnd_be #%0d got %h want %h", k, dmem_be, st ? exp_be(a, f3) : 4'h0); end
               if (st) begin
                  checks++; if (dmem_wdata !== exp_wd(rs2, f3)) begin errs++; $display("FAIL rnd_wdata #%0d got %h want %h", k, dmem_wdata, exp_wd(rs2, f3)); end
               end
            end
            @(posedge clk); #1;
            if (c < d || mis) begin
               wb_inst = 0; wb_pc = 0; wb_alu = 0; wb_data = 0;
            end else begin
               wb_inst = inst; wb_pc = pc; wb_alu = alu; wb_data = ld ? exp_load(rd, a, f3) : 32'h0;
            end
            checks++; if (inst_Wb !== wb_inst || pc_Wb !== wb_pc || alu_out_Wb !== wb_alu) begin errs++; $display("FAIL rnd_wb #%0d got %h %h %h want %h %h %h", k, inst_Wb, pc_Wb, alu_out_Wb, wb_inst, wb_pc, wb_alu); end
            checks++; if (mem_data_Wb !== wb_data) begin errs++; $display("FAIL rnd_data #%0d f3=%0d a=%0d got %h want %h", k, f3, a, mem_data_Wb, wb_data); end
            checks++; if (mem_err !== mis) begin errs++; $display("FAIL rnd_err #%0d got %b want %b", k, mem_err, mis); end
         end
      end
   endtask
   initial begin
      drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      test_reset;
      test_lw;
      test_lb_wait;
      test_sh;
      test_timeout;
      test_ready_at_limit;
      test_misalign;
      test_reset_busy;
      test_random(300);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
